z80_busrq_arbiter: RTL and testbench

//  Shares the Z80 external bus between NUM_MASTERS bus masters (DMA, video, debug).

---
 rtl/z80_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 29 ++
 rtl/z80_busrq_arbiter.sv | 145 ++++++++++++++
 tb/tb_z80_busrq_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/z80_arb_pkg.sv
// Shared types for the Z80 bus-request arbiter.
package z80_arb_pkg;

  localparam int ARB_MAX_MASTERS = 8;

  typedef enum logic [2:0] {
    IDLE,
    REQUEST,
    GRANT,
    HANDOVER,
    RELEASE
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: the lowest set req index at or after ptr+1, wrapping at N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic [IW-1:0] index,
  output logic          valid
);

  always_comb begin
    int pos;
    winner = '0;
    index  = '0;
    valid  = 1'b0;
    pos    = 0;
    for (int k = 1; k <= N; k++) begin
      pos = (int'(ptr) + k) % N;
      if (!valid && req[IW'(pos)]) begin
        valid              = 1'b1;
        index              = IW'(pos);
        winner[IW'(pos)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/z80_busrq_arbiter.sv
// Arbitrates the Z80 external bus between several masters via nBUSRQ/nBUSACK.
// One-hot round-robin grants with a dead cycle between owners.
module z80_busrq_arbiter
  import z80_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int MAX_HOLD    = 256,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                   CLK,
  input  logic                   nRESET,
  input  logic [NUM_MASTERS-1:0] req,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [NUM_MASTERS-1:0] revoke,
  output logic                   nBUSRQ,
  input  logic                   nBUSACK,
  output logic                   bus_owned,
  output logic                   ack_timeout
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam int HW = $clog2(MAX_HOLD + 2);
  localparam int AW = $clog2(ACK_TIMEOUT + 2);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [AW-1:0] ACK_MAX  = AW'(ACK_TIMEOUT);
  localparam logic [AW-1:0] ACK_LAST = AW'(ACK_TIMEOUT - 1);

  arb_state_t             state_q, state_d;
  logic [IW-1:0]          owner_q, owner_d, rr_ptr_q;
  logic [HW-1:0]          hold_q, hold_d;
  logic [AW-1:0]          ack_cnt_q;
  logic                   ack_seen_q;
  logic [NUM_MASTERS-1:0] pick_onehot, owner_mask, grant_d;
  logic [IW-1:0]          pick_idx;
  logic                   pick_valid;
  logic                   entering_grant, revoke_d, timeout_d;

  rr_pick #(.N(NUM_MASTERS), .IW(IW)) u_pick (
    .req    (req),
    .ptr    (rr_ptr_q),
    .winner (pick_onehot),
    .index  (pick_idx),
    .valid  (pick_valid)
  );

  assign owner_mask = NUM_MASTERS'(1) << owner_q;

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    hold_d         = hold_q;
    grant_d        = '0;
    entering_grant = 1'b0;
    revoke_d       = 1'b0;
    timeout_d      = 1'b0;

    case (state_q)
      IDLE:     if (|req) state_d = REQUEST;
      REQUEST: begin
        if (!pick_valid) begin
          state_d = RELEASE;
        end else if (!nBUSACK) begin
          state_d = GRANT;
          owner_d = pick_idx;
        end
      end
      GRANT:    if (!req[owner_q]) state_d = (|req) ? HANDOVER : RELEASE;
      HANDOVER: begin
        if (!pick_valid) begin
          state_d = RELEASE;
        end else begin
          state_d = GRANT;
          owner_d = pick_idx;
        end
      end
      RELEASE:  if (nBUSACK) state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    entering_grant = (state_d == GRANT) && (state_q != GRANT);

    if (entering_grant) begin
      hold_d = '0;
    end else if (state_q == GRANT && hold_q != HOLD_MAX) begin
      hold_d = hold_q + 1'b1;
    end

    if (state_d == GRANT) grant_d = entering_grant ? pick_onehot : owner_mask;

    // Revoke is only a request to yield; the grant itself stays until req drops.
    revoke_d = (MAX_HOLD != 0) && (state_q == GRANT) && (state_d == GRANT) &&
               (hold_d == HOLD_MAX) && (|(req & ~owner_mask));

    timeout_d = (ACK_TIMEOUT != 0) && (state_q == REQUEST) && (state_d == REQUEST) &&
                (ack_cnt_q == ACK_LAST);
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= IW'(NUM_MASTERS - 1);
      hold_q      <= '0;
      ack_cnt_q   <= '0;
      ack_seen_q  <= 1'b0;
      grant       <= '0;
      revoke      <= '0;
      nBUSRQ      <= 1'b1;
      bus_owned   <= 1'b0;
      ack_timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      if (entering_grant) rr_ptr_q <= owner_d;

      // Saturating at ACK_TIMEOUT makes the timeout pulse fire once per REQUEST visit.
      if (state_q != REQUEST) begin
        ack_cnt_q <= '0;
      end else if (ack_cnt_q != ACK_MAX) begin
        ack_cnt_q <= ack_cnt_q + 1'b1;
      end

      if (state_q == REQUEST && !nBUSACK) begin
        ack_seen_q <= 1'b1;
      end else if (state_q == RELEASE || state_q == IDLE) begin
        ack_seen_q <= 1'b0;
      end

      grant       <= grant_d;
      revoke      <= revoke_d ? owner_mask : '0;
      nBUSRQ      <= (state_d == IDLE) || (state_d == RELEASE);
      bus_owned   <= (state_d == GRANT);
      ack_timeout <= timeout_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (nRESET) begin
      a_grant_onehot: assert ($onehot0(grant));
      a_grant_needs_ack: assert (grant == '0 || (!nBUSRQ && ack_seen_q));
    end
  end

endmodule

// File: tb/tb_z80_busrq_arbiter.sv
// Directed bench for z80_busrq_arbiter: a simple CPU ack model plus a grant scoreboard.
module tb_z80_busrq_arbiter;

  localparam int N = 4;

  logic         CLK = 1'b0;
  logic         nRESET;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic [N-1:0] revoke;
  logic         nBUSRQ;
  logic         nBUSACK = 1'b1;
  logic         bus_owned;
  logic         ack_timeout;

  int           n_checks  = 0;
  int           n_pass    = 0;
  int           ack_delay = 3;
  int           to_pulses = 0;
  logic [N-1:0] prev_grant = '0;
  logic [N-1:0] exp_q[$];

  z80_busrq_arbiter #(
    .NUM_MASTERS (N),
    .MAX_HOLD    (8),
    .ACK_TIMEOUT (64)
  ) dut (
    .CLK         (CLK),
    .nRESET      (nRESET),
    .req         (req),
    .grant       (grant),
    .revoke      (revoke),
    .nBUSRQ      (nBUSRQ),
    .nBUSACK     (nBUSACK),
    .bus_owned   (bus_owned),
    .ack_timeout (ack_timeout)
  );

  initial forever #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic applyStimulus(input logic [N-1:0] r);
    req = r;
  endtask

  task automatic wait_grant(input int limit, output int cycles, output bit ok);
    ok     = 1'b0;
    cycles = 0;
    while (!ok && cycles < limit) begin
      @(negedge CLK);
      cycles++;
      if (grant != '0) ok = 1'b1;
    end
  endtask

  task automatic do_reset();
    req    = '0;
    nRESET = 1'b0;
    step(2);
    nRESET = 1'b1;
  endtask

  // CPU model: acknowledges ack_delay cycles after nBUSRQ falls, releases at once.
  always @(negedge CLK) begin
    int rq_cycles;
    if (nBUSRQ !== 1'b0) begin
      rq_cycles = 0;
      nBUSACK   = 1'b1;
    end else begin
      rq_cycles++;
      if (rq_cycles >= ack_delay) nBUSACK = 1'b0;
    end
  end

  // Scoreboard monitor: every new non-zero grant must match the next queued owner.
  always @(negedge CLK) begin
    if (ack_timeout === 1'b1) to_pulses++;
    if (grant != '0 && grant != prev_grant) begin
      if (exp_q.size() == 0) checkOutput("grant_unexpected", 32'(grant), 32'(0));
      else checkOutput("grant_order", 32'(grant), 32'(exp_q.pop_front()));
    end
    prev_grant = grant;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int           cyc;
    bit           ok;
    int           zeros;
    int           base;
    logic [N-1:0] cur;
    logic [N-1:0] r;

    nRESET = 1'b0;
    req    = '0;
    step(2);
    checkOutput("rst_grant", 32'(grant), 32'(0));
    checkOutput("rst_nbusrq", 32'(nBUSRQ), 32'(1));
    checkOutput("rst_revoke", 32'(revoke), 32'(0));
    checkOutput("rst_bus_owned", 32'(bus_owned), 32'(0));
    checkOutput("rst_ack_timeout", 32'(ack_timeout), 32'(0));
    nRESET = 1'b1;

    $display("[TB] single master with ack after 3 cycles");
    exp_q.push_back(4'b0001);
    applyStimulus(4'b0001);
    wait_grant(20, cyc, ok);
    checkOutput("t1_grant_seen", 32'(ok), 32'(1));
    checkOutput("t1_latency", 32'(cyc), 32'(4));
    checkOutput("t1_bus_owned", 32'(bus_owned), 32'(1));
    applyStimulus(4'b0000);
    step(1);
    checkOutput("t1_release_nbusrq", 32'(nBUSRQ), 32'(1));
    checkOutput("t1_release_grant", 32'(grant), 32'(0));
    step(1);
    checkOutput("t1_idle_nbusrq", 32'(nBUSRQ), 32'(1));
    step(2);

    $display("[TB] four masters, round-robin handovers");
    do_reset();
    for (int i = 0; i < N; i++) exp_q.push_back(4'(1) << i);
    r = 4'b1111;
    applyStimulus(r);
    wait_grant(20, cyc, ok);
    checkOutput("t2_grant_seen", 32'(ok), 32'(1));
    for (int i = 0; i < N; i++) begin
      cur = 4'(1) << i;
      step(5);
      checkOutput("t2_no_revoke", 32'(revoke), 32'(0));
      r = r & ~cur;
      applyStimulus(r);
      if (i < N - 1) begin
        zeros = 0;
        step(1);
        while (grant == '0 && zeros < 10) begin
          zeros++;
          step(1);
        end
        checkOutput("t2_dead_cycles", 32'(zeros), 32'(1));
      end else begin
        step(1);
        checkOutput("t2_final_nbusrq", 32'(nBUSRQ), 32'(1));
      end
    end
    step(3);

    $display("[TB] hold limit raises revoke");
    do_reset();
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0100);
    applyStimulus(4'b0001);
    wait_grant(20, cyc, ok);
    checkOutput("t3_grant_seen", 32'(ok), 32'(1));
    step(3);
    applyStimulus(4'b0101);
    step(4);
    checkOutput("t3_revoke_early", 32'(revoke), 32'(0));
    step(1);
    checkOutput("t3_revoke_at_hold", 32'(revoke), 32'(4'b0001));
    checkOutput("t3_grant_kept", 32'(grant), 32'(4'b0001));
    step(2);
    checkOutput("t3_revoke_held", 32'(revoke), 32'(4'b0001));
    applyStimulus(4'b0100);
    step(1);
    checkOutput("t3_dead_grant", 32'(grant), 32'(0));
    checkOutput("t3_dead_revoke", 32'(revoke), 32'(0));
    checkOutput("t3_dead_nbusrq", 32'(nBUSRQ), 32'(0));
    step(1);
    checkOutput("t3_next_grant", 32'(grant), 32'(4'b0100));
    applyStimulus(4'b0000);
    step(4);

    $display("[TB] late ack produces one timeout pulse");
    do_reset();
    ack_delay = 70;
    base      = to_pulses;
    exp_q.push_back(4'b0001);
    applyStimulus(4'b0001);
    wait_grant(100, cyc, ok);
    checkOutput("t4_grant_seen", 32'(ok), 32'(1));
    checkOutput("t4_latency", 32'(cyc), 32'(71));
    checkOutput("t4_timeout_pulses", 32'(to_pulses - base), 32'(1));
    applyStimulus(4'b0000);
    step(4);
    ack_delay = 3;

    $display("[TB] reset during grant");
    exp_q.push_back(4'b0010);
    applyStimulus(4'b1111);
    wait_grant(20, cyc, ok);
    checkOutput("t5_grant_seen", 32'(ok), 32'(1));
    step(2);
    nRESET = 1'b0;
    step(1);
    checkOutput("t5_rst_grant", 32'(grant), 32'(0));
    checkOutput("t5_rst_nbusrq", 32'(nBUSRQ), 32'(1));
    checkOutput("t5_rst_revoke", 32'(revoke), 32'(0));
    checkOutput("t5_rst_bus_owned", 32'(bus_owned), 32'(0));
    exp_q.push_back(4'b0001);
    nRESET = 1'b1;
    wait_grant(20, cyc, ok);
    checkOutput("t5_regrant_seen", 32'(ok), 32'(1));
    applyStimulus(4'b0000);
    step(4);

    $display("[TB] request withdrawn before ack");
    ack_delay = 20;
    applyStimulus(4'b0010);
    step(4);
    checkOutput("t6_requesting", 32'(nBUSRQ), 32'(0));
    applyStimulus(4'b0000);
    step(1);
    checkOutput("t6_release_nbusrq", 32'(nBUSRQ), 32'(1));
    step(30);
    checkOutput("t6_no_grant", 32'(grant), 32'(0));
    checkOutput("t6_no_bus_owned", 32'(bus_owned), 32'(0));
    ack_delay = 3;

    checkOutput("queue_drained", 32'(exp_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
